regfile_writeback: RTL

Write-side controller for the RV32I register file: drives the single write port (we/wa/wdata) from two result producers, the single-cycle ALU and the multi-cycle load unit. Keeps a per-register busy scoreboard so decode stalls on RAW/WAW hazards. The register file has no write-to-read bypass, so the scoreboard interlock is the only hazard protection. Sits between execute/memory stages and regfile; decode consumes the stall output.

---
 rtl/regfile_writeback_pkg.sv | 19 +
 rtl/wb_fifo.sv | 48 ++++
 rtl/regfile_writeback.sv | 116 +++++++++++
 3 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared constants and types for the register-file write-side controller.
package regfile_writeback_pkg;

  localparam int XLEN           = 32;
  localparam int NREG           = 32;
  localparam int AW             = 5;
  localparam int ALU_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding ALU results until they win the write port.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Write-port arbiter between ALU and load results, plus the busy scoreboard
// that makes decode stall on RAW/WAW hazards.
module regfile_writeback
  import regfile_writeback_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic            stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            we,
  output logic [AW-1:0]   wa,
  output logic [XLEN-1:0] wdata,
  output logic            err_spurious
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // ALU results: alu_ready depends on registered state only. Loads: ld_valid
  // holds rd/data stable until ld_ready, which means "written this cycle".
  // Issue: accepted when issue_valid && !stall.

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  grant_src_t      last_grant;
  logic            err_q;

  wb_entry_t fifo_in;
  wb_entry_t fifo_head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;

  logic conflict;
  logic grant_ld;
  logic grant_fifo;
  logic issue_accept;

  assign fifo_in   = '{rd: alu_rd, data: alu_data};
  assign alu_ready = !fifo_full;
  assign fifo_push = alu_valid && alu_ready && (alu_rd != '0);

  wb_fifo #(
    .WIDTH ($bits(wb_entry_t)),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .data  (fifo_in),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Grants are suppressed during reset so an in-flight load is not consumed.
  always_comb begin
    conflict   = !fifo_empty && ld_valid;
    grant_ld   = !reset && ld_valid && (fifo_empty || (last_grant == GRANT_ALU));
    grant_fifo = !reset && !fifo_empty && !grant_ld;
    wa         = '0;
    wdata      = '0;
    if (grant_ld) begin
      wa    = ld_rd;
      wdata = ld_data;
    end else if (grant_fifo) begin
      wa    = fifo_head.rd;
      wdata = fifo_head.data;
    end
    we       = (grant_ld || grant_fifo) && (wa != '0);
    ld_ready = grant_ld;
    fifo_pop = grant_fifo;
  end

  assign stall = (rs1_used && busy[rs1]) ||
                 (rs2_used && busy[rs2]) ||
                 ((issue_rd != '0) && busy[issue_rd]);

  assign issue_accept = issue_valid && !stall && (issue_rd != '0);

  // Set is applied after clear so a same-cycle set on the written register wins.
  always_comb begin
    busy_next = busy;
    if (we)           busy_next[wa]       = 1'b0;
    if (issue_accept) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      last_grant <= GRANT_ALU;
      err_q      <= 1'b0;
    end else begin
      busy <= busy_next;
      if (conflict)         last_grant <= grant_ld ? GRANT_LD : GRANT_ALU;
      if (we && !busy[wa])  err_q      <= 1'b1;
    end
  end

  assign err_spurious = err_q;

endmodule
